// File: rtl/cksum_update_arbiter_pkg.sv
// Shared definitions for the incremental-checksum datapath.
// Holds the engine FSM encoding and the default checksum width so the
// output-port-lookup checksum stages can reuse them.
package cksum_update_arbiter_pkg;

  localparam int unsigned CSUM_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUM  = 2'd1,
    ST_FOLD = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter_onehot.sv
// Round-robin arbiter with one-hot grant.
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - index of the highest-priority requester this cycle
//   grant - one-hot grant (all-zero when req is all-zero)
// The search starts at ptr and walks upward modulo N.
module rr_arbiter_onehot #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant
);

  int unsigned idx;
  logic        found;

  // First requester at or after ptr, wrapping around.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr) + i) % N;
      if (!found && req[idx[IW-1:0]]) begin
        grant[idx[IW-1:0]] = 1'b1;
        found              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cksum_update_arbiter.sv
// Shared RFC 1624 incremental checksum engine, HC' = ~(~HC + ~m + m'),
// arbitrated round-robin among NUM_REQ requesters, one operation in flight.
// Ports:
//   AXI_ACLK, AXI_RESETN       - clock, synchronous active-low reset
//   req_valid / req_ready      - per-requester request handshake (ready is
//                                combinational, asserted only in IDLE)
//   req_old_csum/old/new_field - per-requester operands, requester i in slice i
//   resp_valid / resp_ready    - per-requester response handshake (one-hot)
//   resp_csum                  - updated checksum, held between responses
module cksum_update_arbiter
  import cksum_update_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned CSUM_WIDTH = CSUM_WIDTH_DEF
) (
  input  logic                            AXI_ACLK,
  input  logic                            AXI_RESETN,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*CSUM_WIDTH-1:0]   req_old_csum,
  input  logic [NUM_REQ*CSUM_WIDTH-1:0]   req_old_field,
  input  logic [NUM_REQ*CSUM_WIDTH-1:0]   req_new_field,
  output logic [NUM_REQ-1:0]              resp_valid,
  input  logic [NUM_REQ-1:0]              resp_ready,
  output logic [CSUM_WIDTH-1:0]           resp_csum
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned SW = CSUM_WIDTH + 2;

  state_t                state_q, state_d;
  logic [IW-1:0]         ptr_q, owner_q, win_idx, ptr_inc;
  logic [CSUM_WIDTH-1:0] hc_q, m_q, mp_q;
  logic [CSUM_WIDTH-1:0] hc_sel, m_sel, mp_sel;
  logic [SW-1:0]         sum_q, sum_c;
  logic [CSUM_WIDTH:0]   fold1_c, fold2_c;
  logic [NUM_REQ-1:0]    grant;
  logic                  accept_c, resp_hs_c;

  rr_arbiter_onehot #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  // Encode the grant and pick the winner's operand slices.
  always_comb begin
    win_idx = '0;
    hc_sel  = '0;
    m_sel   = '0;
    mp_sel  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_idx = IW'(i);
        hc_sel  = req_old_csum[i*CSUM_WIDTH +: CSUM_WIDTH];
        m_sel   = req_old_field[i*CSUM_WIDTH +: CSUM_WIDTH];
        mp_sel  = req_new_field[i*CSUM_WIDTH +: CSUM_WIDTH];
      end
    end
  end

  // Three-term sum needs two guard bits; two end-around folds always suffice.
  always_comb begin
    sum_c   = {2'b00, ~hc_q} + {2'b00, ~m_q} + {2'b00, mp_q};
    fold1_c = {1'b0, sum_q[CSUM_WIDTH-1:0]}
            + {{(CSUM_WIDTH-1){1'b0}}, sum_q[SW-1:CSUM_WIDTH]};
    fold2_c = {1'b0, fold1_c[CSUM_WIDTH-1:0]}
            + {{CSUM_WIDTH{1'b0}}, fold1_c[CSUM_WIDTH]};
    ptr_inc = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d    = state_q;
    req_ready  = '0;
    resp_valid = '0;
    accept_c   = 1'b0;
    resp_hs_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (AXI_RESETN && (|req_valid)) begin
          req_ready = grant;
          accept_c  = 1'b1;
          state_d   = ST_SUM;
        end
      end
      ST_SUM:  state_d = ST_FOLD;
      ST_FOLD: state_d = ST_RESP;
      ST_RESP: begin
        resp_valid[owner_q] = 1'b1;
        if (resp_ready[owner_q]) begin
          resp_hs_c = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, operand and result registers.
  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_RESETN) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      hc_q      <= '0;
      m_q       <= '0;
      mp_q      <= '0;
      sum_q     <= '0;
      resp_csum <= '0;
    end else begin
      state_q <= state_d;
      if (accept_c) begin
        owner_q <= win_idx;
        hc_q    <= hc_sel;
        m_q     <= m_sel;
        mp_q    <= mp_sel;
      end
      if (state_q == ST_SUM) begin
        sum_q <= sum_c;
      end
      if (state_q == ST_FOLD) begin
        resp_csum <= ~fold2_c[CSUM_WIDTH-1:0];
      end
      if (resp_hs_c) begin
        ptr_q <= ptr_inc;
      end
    end
  end

endmodule
